// File: rtl/dac_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_frame_sequencer
// Purpose  : Snapshots eight DAC channel codes on trigger, sends one serializer
//            word per enabled channel, then pulses LDAC to update all outputs.
// Revision : 1.0
// ============================================================================
module dac_frame_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int LDAC_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trigger,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     clr_overrun,
  output logic [15:0]              ser_data,
  output logic                     ser_start,
  input  logic                     ser_done,
  output logic                     LDAC,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam int CNT_W = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_LDAC   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  logic [2:0]               state_q,      state_d;
  logic [IDX_W-1:0]         idx_q,        idx_d;
  logic [NUM_CH*DATA_W-1:0] snap_data_q,  snap_data_d;
  logic [NUM_CH-1:0]        snap_en_q,    snap_en_d;
  logic [CNT_W-1:0]         cnt_q,        cnt_d;
  logic [15:0]              ser_data_q,   ser_data_d;
  logic                     ser_start_q,  ser_start_d;
  logic                     ldac_q,       ldac_d;
  logic                     busy_q,       busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q,    overrun_d;

  logic [2:0]               w_ch;
  logic [11:0]              w_code;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_en_d    = snap_en_q;
    cnt_d        = cnt_q;
    ser_data_d   = ser_data_q;
    ser_start_d  = 1'b0;
    ldac_d       = ldac_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    w_ch   = idx_q[2:0];
    w_code = '0;
    w_code[DATA_W-1:0] = snap_data_q[w_ch*DATA_W +: DATA_W];

    // A dropped trigger takes priority over a simultaneous clear.
    if (trigger && busy_q) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          snap_data_d = ch_data;
          snap_en_d   = ch_en;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (snap_en_q == '0) begin
          state_d = ST_FINISH;
        end else if (idx_q == IDX_W'(NUM_CH)) begin
          ldac_d  = 1'b0;
          cnt_d   = CNT_W'(LDAC_CYCLES - 1);
          state_d = ST_LDAC;
        end else if (snap_en_q[w_ch]) begin
          ser_data_d  = {1'b0, w_ch, w_code};
          ser_start_d = 1'b1;
          state_d     = ST_GUARD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // One dead cycle so a done level left over from the last word is ignored.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ser_done) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
      end
      ST_LDAC: begin
        if (cnt_q == '0) begin
          ldac_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FINISH: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_en_q    <= '0;
      cnt_q        <= '0;
      ser_data_q   <= '0;
      ser_start_q  <= 1'b0;
      ldac_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_en_q    <= snap_en_d;
      cnt_q        <= cnt_d;
      ser_data_q   <= ser_data_d;
      ser_start_q  <= ser_start_d;
      ldac_q       <= ldac_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ser_data   = ser_data_q;
  assign ser_start  = ser_start_q;
  assign LDAC       = ldac_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
